axis_video_pattern_gen: RTL and testbench
=========================================

// Module: axis_video_pattern_gen
// PURPOSE
//  AXI4-Stream video source: generates frames of 24-bit RGB test patterns (colour bars,
//  ramp, checkerboard, solid) with tuser=SOF and tlast=EOL.
//  Feeds the filter chain or v_axi4s_vid_out in place of v_vid_in_axi4s for bring-up and
//  regression.
//  Honours full tready backpressure and inserts a programmable inter-line gap.
// PARAMETERS
//  H_ACTIVE  1920  pixels per line; multiple of 8, >=8
//  V_ACTIVE  1080  lines per frame, >=1
//  H_GAP     0     idle cycles (tvalid=0) after each line's tlast handshake
//  FCNT_W    16    width of frame_count
// PORTS
//  aclk                 in   1       clock
//  aresetn              in   1       reset: synchronous, active-low
//  enable               in   1       run; sampled at frame boundaries only
//  pattern_sel          in   2       0 bars, 1 ramp, 2 checker, 3 solid; latched at SOF
//  solid_color          in   24      pattern 3 value; latched at SOF
//  m_axis_video_tdata   out  24      pixel {R[23:16],B[15:8],G[7:0]} (codebase packing)
//  m_axis_video_tvalid  out  1       pixel valid
//  m_axis_video_tready  in   1       sink ready
//  m_axis_video_tuser   out  1       1 on first pixel of frame (x=0,y=0)
//  m_axis_video_tlast   out  1       1 on last pixel of each line (x=H_ACTIVE-1)
//  frame_done           out  1       1-cycle pulse on handshake of final pixel of frame
//  frame_count          out  FCNT_W  completed frames, wraps modulo 2^FCNT_W
// BEHAVIOUR
//  Reset: state=IDLE; tvalid/tuser/tlast/frame_done=0; tdata=0; frame_count=0; x=y=0.
//  Handshake = tvalid & tready. All outputs registered.
//  Once tvalid=1, tdata/tuser/tlast are held stable until handshake. tvalid never drops
//  without a handshake (AXI4-S rule).
//  FSM:
//   IDLE:   tvalid=0. If enable: latch pattern_sel/solid_color, load pixel (0,0) with
//           tuser=1, go ACTIVE. First tvalid appears 1 cycle after enable is seen.
//   ACTIVE: on handshake advance x. At x=H_ACTIVE-1 (tlast) wrap x=0 and inc y.
//           At y=V_ACTIVE-1 also wrap y=0, pulse frame_done, inc frame_count.
//           After tlast handshake: if H_GAP>0 go GAP (tvalid=0 next cycle); else
//           present next pixel next cycle. Back-to-back handshakes sustain 1 px/clk.
//           After the frame's final handshake: if enable, start new frame (re-latch
//           selects, tuser=1); else go IDLE.
//   GAP:    tvalid=0 for exactly H_GAP cycles, then ACTIVE with next line's pixel 0.
//           After the last line, the gap also precedes the IDLE/new-frame decision.
//  enable=0 mid-frame: the current frame completes in full; no truncated frames.
//  pattern_sel/solid_color changes mid-frame are ignored until the next SOF.
//  Pixel function of (x,y) and latched selects:
//   bars:    bar = x/(H_ACTIVE/8), tracked by a sub-counter (no divider). Order:
//            white FFFFFF, yellow FF00FF, cyan 00FFFF, green 0000FF, magenta FFFF00,
//            red FF0000, blue 00FF00, black 000000 (packed R,B,G).
//   ramp:    g=x[7:0]; tdata={g,g,g}.
//   checker: white if x[4]^y[4], else black (16x16 squares).
//   solid:   tdata=solid_color.
//  tready low for any duration: no state advance, outputs frozen. tready may be high in
//  GAP/IDLE with no effect.
//  Reset mid-frame: immediate return to reset values. The next frame restarts at (0,0)
//  with tuser=1.
// STRUCTURE
//  video_pkg (shared): pattern_e enum {PAT_BARS,PAT_RAMP,PAT_CHECK,PAT_SOLID};
//   localparam colour constants C_WHITE..C_BLACK in R,B,G packing; pixel_t = logic [23:0].
//  Sub-module vpg_pixel_calc: combinational (pattern, x, y, bar_idx, solid) -> pixel_t.
//  The top holds the FSM, the x/y/bar/gap counters and the output register.
// TESTING (bench H_ACTIVE=16, V_ACTIVE=4, H_GAP=2 unless noted)
//  1 enable=1, sel=0, tready=1 -> 64 px/frame; tuser only on px0; tlast on x=15;
//    bar pairs FFFFFF,FFFFFF,FF00FF,...,000000; frame_done 1 cycle, frame_count=1.
//  2 sel=1 -> line tdata 000000,010101,...,0F0F0F; exactly 2 tvalid=0 cycles after each
//    tlast; H_GAP=0 build gives 64 consecutive valid cycles.
//  3 sel=2 with H_ACTIVE=32, V_ACTIVE=32 -> (0,0)=000000, (16,0)=FFFFFF, (16,16)=000000.
//  4 random tready (~50%) -> tvalid never drops early; held tdata/tuser/tlast stable;
//    pixel sequence identical to test 1.
//  5 sel 3->1 and solid_color change mid-frame; enable=0 at px 20 -> frame finishes as
//    solid, then IDLE (tvalid=0); re-enable -> ramp frame with tuser=1.
//  6 aresetn=0 at px 30 -> next cycle all outputs 0, frame_count=0; after release with
//    enable=1 -> first tvalid pixel is (0,0) with tuser=1.

Source files
------------

// File: rtl/video_pkg.sv
// Shared types and colour constants for the video pattern generator.
// Colours use the codebase packing {R[23:16], B[15:8], G[7:0]}.
package video_pkg;

    typedef logic [23:0] pixel_t;

    typedef enum logic [1:0] {
        PAT_BARS,
        PAT_RAMP,
        PAT_CHECK,
        PAT_SOLID
    } pattern_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_GAP
    } vpg_state_e;

    localparam pixel_t C_WHITE   = 24'hFFFFFF;
    localparam pixel_t C_YELLOW  = 24'hFF00FF;
    localparam pixel_t C_CYAN    = 24'h00FFFF;
    localparam pixel_t C_GREEN   = 24'h0000FF;
    localparam pixel_t C_MAGENTA = 24'hFFFF00;
    localparam pixel_t C_RED     = 24'hFF0000;
    localparam pixel_t C_BLUE    = 24'h00FF00;
    localparam pixel_t C_BLACK   = 24'h000000;

    function automatic pixel_t bar_color(input logic [2:0] idx);
        pixel_t c;
        c = C_BLACK;
        unique case (idx)
            3'd0: c = C_WHITE;
            3'd1: c = C_YELLOW;
            3'd2: c = C_CYAN;
            3'd3: c = C_GREEN;
            3'd4: c = C_MAGENTA;
            3'd5: c = C_RED;
            3'd6: c = C_BLUE;
            3'd7: c = C_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vpg_pixel_calc.sv
// Combinational pixel value for one coordinate of the selected pattern.
// Only x[7:0] and y[4] are needed by any pattern.
module vpg_pixel_calc
    import video_pkg::*;
(
    input  pattern_e    pattern,
    input  logic [7:0]  x,
    input  logic        y4,
    input  logic [2:0]  bar_idx,
    input  pixel_t      solid,
    output pixel_t      pixel
);

    always_comb begin
        pixel = C_BLACK;
        unique case (pattern)
            PAT_BARS:  pixel = bar_color(bar_idx);
            PAT_RAMP:  pixel = {x, x, x};
            PAT_CHECK: pixel = (x[4] ^ y4) ? C_WHITE : C_BLACK;
            PAT_SOLID: pixel = solid;
        endcase
    end

endmodule

// File: rtl/axis_video_pattern_gen.sv
// AXI4-Stream RGB test-pattern source with SOF/EOL framing,
// full backpressure and a programmable inter-line gap.
module axis_video_pattern_gen
    import video_pkg::*;
#(
    parameter int H_ACTIVE = 1920,
    parameter int V_ACTIVE = 1080,
    parameter int H_GAP    = 0,
    parameter int FCNT_W   = 16
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              enable,
    input  logic [1:0]        pattern_sel,
    input  logic [23:0]       solid_color,
    output logic [23:0]       m_axis_video_tdata,
    output logic              m_axis_video_tvalid,
    input  logic              m_axis_video_tready,
    output logic              m_axis_video_tuser,
    output logic              m_axis_video_tlast,
    output logic              frame_done,
    output logic [FCNT_W-1:0] frame_count
);

    localparam int XW    = ($clog2(H_ACTIVE + 1) > 8) ? $clog2(H_ACTIVE + 1) : 8;
    localparam int YW    = ($clog2(V_ACTIVE + 1) > 5) ? $clog2(V_ACTIVE + 1) : 5;
    localparam int BAR_W = H_ACTIVE / 8;
    localparam int BW    = $clog2(BAR_W + 1);
    localparam int GW    = $clog2(H_GAP + 2);

    localparam logic [XW-1:0] X_LAST   = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_ACTIVE - 1);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((H_GAP > 0) ? H_GAP - 1 : 0);

    vpg_state_e        state, state_n;
    logic [XW-1:0]     x, x_n;
    logic [YW-1:0]     y, y_n;
    logic [BW-1:0]     bar_cnt, bar_cnt_n;
    logic [2:0]        bar_idx, bar_idx_n;
    logic [GW-1:0]     gap_cnt, gap_cnt_n;
    logic              eof_q, eof_n;
    pattern_e          pat_q, pat_n;
    pixel_t            solid_q, solid_n;
    pixel_t            pix, data_n;
    logic              valid_n, user_n, last_n, fdone_n;
    logic [FCNT_W-1:0] fcnt_n;
    logic              hs, load, start;

    assign hs = m_axis_video_tvalid & m_axis_video_tready;

    vpg_pixel_calc u_calc (
        .pattern (pat_n),
        .x       (x_n[7:0]),
        .y4      (y_n[4]),
        .bar_idx (bar_idx_n),
        .solid   (solid_n),
        .pixel   (pix)
    );

    always_comb begin
        state_n   = state;
        x_n       = x;
        y_n       = y;
        bar_cnt_n = bar_cnt;
        bar_idx_n = bar_idx;
        gap_cnt_n = gap_cnt;
        eof_n     = eof_q;
        pat_n     = pat_q;
        solid_n   = solid_q;
        valid_n   = m_axis_video_tvalid;
        user_n    = m_axis_video_tuser;
        last_n    = m_axis_video_tlast;
        fdone_n   = 1'b0;
        fcnt_n    = frame_count;
        load      = 1'b0;
        start     = 1'b0;

        unique case (state)
            ST_IDLE: begin
                start = enable;
            end
            ST_ACTIVE: begin
                if (hs) begin
                    user_n = 1'b0;
                    if (x != X_LAST) begin
                        x_n  = x + 1'b1;
                        load = 1'b1;
                        if (bar_cnt == BAR_LAST) begin
                            bar_cnt_n = '0;
                            bar_idx_n = bar_idx + 1'b1;
                        end else begin
                            bar_cnt_n = bar_cnt + 1'b1;
                        end
                    end else begin
                        x_n       = '0;
                        bar_cnt_n = '0;
                        bar_idx_n = '0;
                        eof_n     = (y == Y_LAST);
                        if (y == Y_LAST) begin
                            y_n     = '0;
                            fdone_n = 1'b1;
                            fcnt_n  = frame_count + 1'b1;
                        end else begin
                            y_n = y + 1'b1;
                        end
                        if (H_GAP > 0) begin
                            state_n   = ST_GAP;
                            gap_cnt_n = '0;
                            valid_n   = 1'b0;
                            last_n    = 1'b0;
                        end else if (y != Y_LAST) begin
                            load = 1'b1;
                        end else if (enable) begin
                            start = 1'b1;
                        end else begin
                            state_n = ST_IDLE;
                            valid_n = 1'b0;
                            last_n  = 1'b0;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    if (!eof_q) begin
                        state_n = ST_ACTIVE;
                        load    = 1'b1;
                    end else if (enable) begin
                        start = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    gap_cnt_n = gap_cnt + 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // New frame: selects are captured here and held until the next SOF
        if (start) begin
            state_n   = ST_ACTIVE;
            pat_n     = pattern_e'(pattern_sel);
            solid_n   = solid_color;
            x_n       = '0;
            y_n       = '0;
            bar_cnt_n = '0;
            bar_idx_n = '0;
            eof_n     = 1'b0;
            user_n    = 1'b1;
            load      = 1'b1;
        end

        if (load) begin
            valid_n = 1'b1;
            last_n  = (x_n == X_LAST);
        end
        data_n = load ? pix : m_axis_video_tdata;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state               <= ST_IDLE;
            x                   <= '0;
            y                   <= '0;
            bar_cnt             <= '0;
            bar_idx             <= '0;
            gap_cnt             <= '0;
            eof_q               <= 1'b0;
            pat_q               <= PAT_BARS;
            solid_q             <= '0;
            m_axis_video_tdata  <= '0;
            m_axis_video_tvalid <= 1'b0;
            m_axis_video_tuser  <= 1'b0;
            m_axis_video_tlast  <= 1'b0;
            frame_done          <= 1'b0;
            frame_count         <= '0;
        end else begin
            state               <= state_n;
            x                   <= x_n;
            y                   <= y_n;
            bar_cnt             <= bar_cnt_n;
            bar_idx             <= bar_idx_n;
            gap_cnt             <= gap_cnt_n;
            eof_q               <= eof_n;
            pat_q               <= pat_n;
            solid_q             <= solid_n;
            m_axis_video_tdata  <= data_n;
            m_axis_video_tvalid <= valid_n;
            m_axis_video_tuser  <= user_n;
            m_axis_video_tlast  <= last_n;
            frame_done          <= fdone_n;
            frame_count         <= fcnt_n;
        end
    end

endmodule

// File: tb/tb_axis_video_pattern_gen.sv
// Scoreboard bench: frames are pushed as expected pixel lists from a
// pattern model; a negedge monitor pops and compares on each handshake.
module tb_axis_video_pattern_gen;

    localparam int H  = 16;
    localparam int V  = 4;
    localparam int G  = 2;
    localparam int H2 = 32;
    localparam int V2 = 32;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic [23:0] solid = 24'd0;
    logic [23:0] tdata;
    logic        tvalid;
    logic        tready = 1'b1;
    logic        tuser, tlast, frame_done;
    logic [15:0] frame_count;

    logic        enable2 = 1'b0;
    logic [1:0]  sel2 = 2'd2;
    logic [23:0] solid2 = 24'd0;
    logic        tready2 = 1'b1;
    logic [23:0] tdata2;
    logic        tvalid2, tuser2, tlast2, fdone2;
    logic [15:0] fcount2;

    always #5 aclk = ~aclk;

    axis_video_pattern_gen #(.H_ACTIVE(H), .V_ACTIVE(V), .H_GAP(G), .FCNT_W(16)) u_dut (
        .aclk(aclk), .aresetn(aresetn), .enable(enable),
        .pattern_sel(sel), .solid_color(solid),
        .m_axis_video_tdata(tdata), .m_axis_video_tvalid(tvalid),
        .m_axis_video_tready(tready), .m_axis_video_tuser(tuser),
        .m_axis_video_tlast(tlast), .frame_done(frame_done),
        .frame_count(frame_count)
    );

    axis_video_pattern_gen #(.H_ACTIVE(H2), .V_ACTIVE(V2), .H_GAP(0), .FCNT_W(16)) u_dut2 (
        .aclk(aclk), .aresetn(aresetn), .enable(enable2),
        .pattern_sel(sel2), .solid_color(solid2),
        .m_axis_video_tdata(tdata2), .m_axis_video_tvalid(tvalid2),
        .m_axis_video_tready(tready2), .m_axis_video_tuser(tuser2),
        .m_axis_video_tlast(tlast2), .frame_done(fdone2),
        .frame_count(fcount2)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout expected completion", name);
    endtask

    function automatic logic [23:0] ref_pix(input int pat, input logic [23:0] s,
                                            input int x, input int y, input int h);
        logic [7:0] g;
        case (pat)
            0: begin
                case (x / (h / 8))
                    0: return 24'hFFFFFF;
                    1: return 24'hFF00FF;
                    2: return 24'h00FFFF;
                    3: return 24'h0000FF;
                    4: return 24'hFFFF00;
                    5: return 24'hFF0000;
                    6: return 24'h00FF00;
                    default: return 24'h000000;
                endcase
            end
            1: begin
                g = x[7:0];
                return {g, g, g};
            end
            2: return ((((x >> 4) ^ (y >> 4)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
            default: return s;
        endcase
    endfunction

    typedef struct packed {
        logic [23:0] d;
        logic        u;
        logic        l;
        logic        e;
    } exp_t;

    exp_t q[$];

    task automatic push_frame(input int pat, input logic [23:0] s);
        exp_t it;
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                it.d = ref_pix(pat, s, x, y, H);
                it.u = (x == 0 && y == 0);
                it.l = (x == H - 1);
                it.e = (x == H - 1 && y == V - 1);
                q.push_back(it);
            end
        end
    endtask

    bit   mon_on = 0;
    int   px_seen = 0;
    int   fc_model = 0;
    bit   fd_pending = 0;
    bit   prev_stall = 0;
    exp_t prev_out;
    bit   gap_track = 0;
    int   gap_n = 0;
    bit   rand_rdy = 0;

    always @(negedge aclk) begin
        exp_t it;
        if (!mon_on) begin
            fd_pending = 0;
            prev_stall = 0;
            gap_track  = 0;
        end else begin
            if (fd_pending) fc_model++;
            check("frame_done", 32'(frame_done), 32'(fd_pending));
            check("frame_count", 32'(frame_count), fc_model & 32'hFFFF);
            if (gap_track && tvalid) begin
                check("line_gap", gap_n, G);
                gap_track = 0;
            end else if (gap_track) begin
                gap_n++;
            end
            if (prev_stall) begin
                check("hold_valid", 32'(tvalid), 32'd1);
                check("hold_data", {tdata, tuser, tlast},
                      {prev_out.d, prev_out.u, prev_out.l});
            end
            fd_pending = 0;
            if (tvalid && tready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pixel: got %h expected none", tdata);
                end else begin
                    it = q.pop_front();
                    check("tdata", 32'(tdata), 32'(it.d));
                    check("tuser", 32'(tuser), 32'(it.u));
                    check("tlast", 32'(tlast), 32'(it.l));
                    fd_pending = it.e;
                    if (it.l && !it.e) begin
                        gap_track = 1;
                        gap_n = 0;
                    end
                end
                px_seen++;
            end
            prev_stall = tvalid && !tready;
            prev_out.d = tdata;
            prev_out.u = tuser;
            prev_out.l = tlast;
            prev_out.e = 1'b0;
        end
    end

    initial begin
        forever begin
            @(posedge aclk);
            #1;
            tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_px(input int n, input int budget);
        int c = 0;
        do begin
            @(posedge aclk);
            c++;
        end while (px_seen < n && c < budget);
        #1;
        if (px_seen < n) fail_now("wait_px");
    endtask

    task automatic wait_drain(input int budget);
        int c = 0;
        do begin
            @(posedge aclk);
            c++;
        end while (q.size() != 0 && c < budget);
        if (q.size() != 0) fail_now("drain");
        repeat (3) @(posedge aclk);
        #1;
    endtask

    task automatic start_one(input logic [1:0] p, input logic [23:0] s);
        sel = p;
        solid = s;
        enable = 1'b1;
        @(posedge aclk);
        #1;
        enable = 1'b0;
        check("first_valid", 32'(tvalid), 32'd1);
    endtask

    initial begin
        int base;
        logic [23:0] s1, s2;
        int vcnt;

        repeat (3) @(posedge aclk);
        #1;
        check("rst_tvalid", 32'(tvalid), 0);
        check("rst_tuser", 32'(tuser), 0);
        check("rst_tlast", 32'(tlast), 0);
        check("rst_fdone", 32'(frame_done), 0);
        check("rst_tdata", 32'(tdata), 0);
        check("rst_fcount", 32'(frame_count), 0);
        aresetn = 1'b1;
        mon_on = 1;

        // two back-to-back colour-bar frames
        push_frame(0, 24'd0);
        push_frame(0, 24'd0);
        sel = 2'd0;
        enable = 1'b1;
        @(posedge aclk);
        #1;
        check("first_valid", 32'(tvalid), 32'd1);
        check("first_user", 32'(tuser), 32'd1);
        wait_px(px_seen + 70, 400);
        enable = 1'b0;
        wait_drain(400);

        // ramp
        push_frame(1, 24'd0);
        start_one(2'd1, 24'd0);
        wait_drain(400);

        // backpressure on bars and checker
        rand_rdy = 1;
        push_frame(0, 24'd0);
        start_one(2'd0, 24'd0);
        wait_drain(1000);
        push_frame(2, 24'd0);
        start_one(2'd2, 24'd0);
        wait_drain(1000);
        rand_rdy = 0;

        // mid-frame select changes and enable drop
        s1 = 24'($urandom);
        s2 = 24'($urandom);
        push_frame(3, s1);
        base = px_seen;
        sel = 2'd3;
        solid = s1;
        enable = 1'b1;
        @(posedge aclk);
        #1;
        wait_px(base + 20, 300);
        sel = 2'd1;
        solid = s2;
        enable = 1'b0;
        wait_drain(400);
        repeat (8) begin
            @(posedge aclk);
            #1;
            check("idle_tvalid", 32'(tvalid), 0);
        end
        push_frame(1, s2);
        start_one(2'd1, s2);
        sel = 2'($urandom);
        solid = 24'($urandom);
        wait_drain(400);

        // reset mid-frame
        push_frame(0, 24'd0);
        base = px_seen;
        sel = 2'd0;
        enable = 1'b1;
        @(posedge aclk);
        #1;
        wait_px(base + 30, 300);
        mon_on = 0;
        aresetn = 1'b0;
        @(posedge aclk);
        #1;
        check("mid_rst_tvalid", 32'(tvalid), 0);
        check("mid_rst_tuser", 32'(tuser), 0);
        check("mid_rst_tlast", 32'(tlast), 0);
        check("mid_rst_fdone", 32'(frame_done), 0);
        check("mid_rst_tdata", 32'(tdata), 0);
        check("mid_rst_fcount", 32'(frame_count), 0);
        q.delete();
        fc_model = 0;
        aresetn = 1'b1;
        push_frame(0, 24'd0);
        mon_on = 1;
        @(posedge aclk);
        #1;
        check("post_rst_valid", 32'(tvalid), 1);
        check("post_rst_user", 32'(tuser), 1);
        enable = 1'b0;
        wait_drain(400);

        // 32x32 checker with no line gap: one unbroken burst
        enable2 = 1'b1;
        @(posedge aclk);
        #1;
        enable2 = 1'b0;
        check("dut2_first_valid", 32'(tvalid2), 1);
        vcnt = 0;
        for (int i = 0; i < H2 * V2; i++) begin
            @(negedge aclk);
            if (tvalid2) vcnt++;
            check("dut2_tdata", 32'(tdata2), 32'(ref_pix(2, 24'd0, i % H2, i / H2, H2)));
            check("dut2_tuser", 32'(tuser2), 32'(i == 0));
            check("dut2_tlast", 32'(tlast2), 32'((i % H2) == H2 - 1));
            if (i == 0)   check("chk_0_0", 32'(tdata2), 32'h000000);
            if (i == 16)  check("chk_16_0", 32'(tdata2), 32'hFFFFFF);
            if (i == 528) check("chk_16_16", 32'(tdata2), 32'h000000);
        end
        check("dut2_valid_run", vcnt, H2 * V2);
        @(negedge aclk);
        check("dut2_fdone", 32'(fdone2), 1);
        check("dut2_fcount", 32'(fcount2), 1);
        @(negedge aclk);
        check("dut2_idle", 32'(tvalid2), 0);

        mon_on = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
